// File: rtl/mult_param_fast.sv
`default_nettype none
// ============================================================================
// Module   : mult_param_fast
// Purpose  : Sequential unsigned multiplier. Operands are split into WORD_W-bit
//            words, and one word-pair partial product is accumulated per clock.
//            The A word index is the inner loop and the B word index is the
//            outer loop.
// Config   : MULT_ZERO_SKIP_EN - when defined, zero upper words of A and B
//            are skipped so that small operands finish early.
// Revision : 1.0 - initial release
// ============================================================================
module mult_param_fast #(
   parameter int WORD_W  = 16,
   parameter int A_WORDS = 2,
   parameter int B_WORDS = 2
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                start,
   input  logic [A_WORDS*WORD_W-1:0]           a,
   input  logic [B_WORDS*WORD_W-1:0]           b,
   output logic                                busy,
   output logic                                done,
   output logic [(A_WORDS+B_WORDS)*WORD_W-1:0] product
);

   localparam int AW = A_WORDS * WORD_W;
   localparam int BW = B_WORDS * WORD_W;
   localparam int PW = (A_WORDS + B_WORDS) * WORD_W;
   localparam int IW = (A_WORDS > 1) ? $clog2(A_WORDS) : 1;
   localparam int JW = (B_WORDS > 1) ? $clog2(B_WORDS) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [AW-1:0] a_q, a_d;
   logic [BW-1:0] b_q, b_d;
   logic [IW-1:0] i_q, i_d;
   logic [JW-1:0] j_q, j_d;
   logic [IW-1:0] ilast_q, ilast_d;
   logic [JW-1:0] jlast_q, jlast_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [PW-1:0] prod_q, prod_d;

   // Last word index to visit for each operand, evaluated on the live inputs
   // because it is captured on the same edge that samples start.
   logic [IW-1:0] ilast_start;
   logic [JW-1:0] jlast_start;

   logic [WORD_W-1:0]   a_word;
   logic [WORD_W-1:0]   b_word;
   logic [2*WORD_W-1:0] pp;
   logic [31:0]         pp_shift;
   logic [PW-1:0]       pp_aligned;

`ifdef MULT_ZERO_SKIP_EN
   // Highest nonzero word index of A (0 when A is zero, so at least one pass).
   always_comb begin
      ilast_start = '0;
      for (int k = 1; k < A_WORDS; k++) begin
         if (a[k*WORD_W +: WORD_W] != '0) ilast_start = IW'(k);
      end
   end

   // Highest nonzero word index of B (0 when B is zero).
   always_comb begin
      jlast_start = '0;
      for (int k = 1; k < B_WORDS; k++) begin
         if (b[k*WORD_W +: WORD_W] != '0) jlast_start = JW'(k);
      end
   end
`else
   assign ilast_start = IW'(A_WORDS - 1);
   assign jlast_start = JW'(B_WORDS - 1);
`endif

   // One word-pair partial product, aligned to its (i+j) word position.
   always_comb begin
      a_word     = a_q[i_q*WORD_W +: WORD_W];
      b_word     = b_q[j_q*WORD_W +: WORD_W];
      pp         = (2*WORD_W)'(a_word) * (2*WORD_W)'(b_word);
      pp_shift   = (32'(i_q) + 32'(j_q)) * 32'(WORD_W);
      pp_aligned = PW'(pp) << pp_shift;
   end

   // Next-state logic: latch operands on start, then walk i (inner) and j (outer).
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      i_d     = i_q;
      j_d     = j_q;
      ilast_d = ilast_q;
      jlast_d = jlast_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      prod_d  = prod_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               prod_d  = '0;
               i_d     = '0;
               j_d     = '0;
               ilast_d = ilast_start;
               jlast_d = jlast_start;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            prod_d = prod_q + pp_aligned;
            if (i_q == ilast_q) begin
               i_d = '0;
               if (j_q == jlast_q) begin
                  j_d     = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  j_d = j_q + 1'b1;
               end
            end else begin
               i_d = i_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-low reset; reset discards any partial result.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         ilast_q <= '0;
         jlast_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         i_q     <= i_d;
         j_q     <= j_d;
         ilast_q <= ilast_d;
         jlast_q <= jlast_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         prod_q  <= prod_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = prod_q;

endmodule
`default_nettype wire
